// File: rtl/sys_matmul.sv
// sys_matmul: output-stationary systolic matrix multiplier, Y = W x X.
// Square signed matrices of size 2, 4 or up to MAXN, selected per job.
//
// Ports:
//   clk          clock, rising edge
//   rst_n        asynchronous active-low reset
//   in_valid     qualifies matrix; held high for the whole job load
//   matrix       operand word (DW bits, signed); W row-major then X row-major
//   matrix_size  size code sampled on the first load word (0:2, 1:4, 2:8, 3:MAXN)
//   out_valid    qualifies out_value
//   out_value    result word Y[i][j], row-major, sign-extended to OW bits

module sys_matmul #(
    parameter int unsigned DW   = 16,
    parameter int unsigned MAXN = 4,
    parameter int unsigned OW   = 40
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    input  logic [DW-1:0] matrix,
    input  logic [1:0]    matrix_size,
    output logic          out_valid,
    output logic [OW-1:0] out_value
);

    localparam int unsigned IW = $clog2(MAXN);
    localparam int unsigned CW = 8;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] LOAD = 2'd1;
    localparam logic [1:0] FEED = 2'd2;
    localparam logic [1:0] OUT  = 2'd3;

    logic [1:0]    state;
    logic [CW-1:0] n_q;       // job dimension, held for the whole job
    logic [CW-1:0] row_q;     // shared row counter for LOAD and OUT
    logic [CW-1:0] col_q;     // shared column counter for LOAD and OUT
    logic [CW-1:0] feed_cnt;
    logic          x_phase;   // 0 while loading W, 1 while loading X

    logic [DW-1:0] w_mem [MAXN][MAXN];
    logic [DW-1:0] x_mem [MAXN][MAXN];

    logic [CW-1:0] n_m1;
    logic [CW-1:0] feed_end;
    logic          row_last;
    logic          col_last;
    logic          load_last;
    logic          feed_last;

    // Size code to dimension; anything above MAXN clamps to MAXN.
    function automatic logic [CW-1:0] decode_size(input logic [1:0] code);
        logic [CW-1:0] n;
        unique case (code)
            2'd0:    n = 8'd2;
            2'd1:    n = 8'd4;
            2'd2:    n = 8'd8;
            default: n = CW'(MAXN);
        endcase
        if (n > CW'(MAXN)) begin
            n = CW'(MAXN);
        end
        return n;
    endfunction

    assign n_m1      = n_q - 8'd1;
    assign feed_end  = n_q + n_q + n_q - 8'd3;
    assign row_last  = (row_q == n_m1);
    assign col_last  = (col_q == n_m1);
    assign load_last = (state == LOAD) && in_valid && x_phase && row_last && col_last;
    assign feed_last = (state == FEED) && (feed_cnt == feed_end);

    // ------------------------------------------------------------------
    // Control FSM and operand capture
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            n_q      <= '0;
            row_q    <= '0;
            col_q    <= '0;
            feed_cnt <= '0;
            x_phase  <= 1'b0;
            for (int r = 0; r < int'(MAXN); r++) begin
                for (int c = 0; c < int'(MAXN); c++) begin
                    w_mem[r][c] <= '0;
                    x_mem[r][c] <= '0;
                end
            end
        end else begin
            unique case (state)
                IDLE: begin
                    if (in_valid) begin
                        // This word is load index 0, always W[0][0].
                        state       <= LOAD;
                        n_q         <= decode_size(matrix_size);
                        w_mem[0][0] <= matrix;
                        row_q       <= '0;
                        col_q       <= 8'd1;
                        x_phase     <= 1'b0;
                    end
                end
                LOAD: begin
                    if (!in_valid) begin
                        // Abort: partial operands are simply overwritten by the next job.
                        state   <= IDLE;
                        row_q   <= '0;
                        col_q   <= '0;
                        x_phase <= 1'b0;
                    end else begin
                        if (x_phase) begin
                            x_mem[row_q[IW-1:0]][col_q[IW-1:0]] <= matrix;
                        end else begin
                            w_mem[row_q[IW-1:0]][col_q[IW-1:0]] <= matrix;
                        end
                        if (col_last) begin
                            col_q <= '0;
                            if (row_last) begin
                                row_q   <= '0;
                                x_phase <= 1'b1;
                            end else begin
                                row_q <= row_q + 8'd1;
                            end
                        end else begin
                            col_q <= col_q + 8'd1;
                        end
                        if (load_last) begin
                            state    <= FEED;
                            feed_cnt <= '0;
                            x_phase  <= 1'b0;
                        end
                    end
                end
                FEED: begin
                    feed_cnt <= feed_cnt + 8'd1;
                    if (feed_last) begin
                        state    <= OUT;
                        feed_cnt <= '0;
                        row_q    <= '0;
                        col_q    <= '0;
                    end
                end
                OUT: begin
                    if (col_last) begin
                        col_q <= '0;
                        if (row_last) begin
                            row_q <= '0;
                            state <= IDLE;
                        end else begin
                            row_q <= row_q + 8'd1;
                        end
                    end else begin
                        col_q <= col_q + 8'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Skewed edge injection: row i of W on the west edge and column j of X
    // on the north edge both start i (resp. j) cycles late, so operand pair
    // k meets at PE(i,j) in feed cycle i+j+k.
    // ------------------------------------------------------------------
    logic signed [DW-1:0] w_edge [MAXN];
    logic signed [DW-1:0] n_edge [MAXN];

    for (genvar g = 0; g < int'(MAXN); g++) begin : g_edge
        logic [CW:0] kd;     // feed_cnt - g with borrow in the top bit
        logic        live;
        assign kd   = {1'b0, feed_cnt} - {1'b0, CW'(g)};
        assign live = (state == FEED) && (CW'(g) < n_q) && !kd[CW] && (kd[CW-1:0] < n_q);
        assign w_edge[g] = live ? w_mem[g][kd[IW-1:0]] : '0;
        assign n_edge[g] = live ? x_mem[kd[IW-1:0]][g] : '0;
    end

    // ------------------------------------------------------------------
    // PE array. Forwarding registers exist only where a neighbour consumes them.
    // ------------------------------------------------------------------
    logic signed [DW-1:0] a_fwd [MAXN][MAXN-1];
    logic signed [DW-1:0] b_fwd [MAXN-1][MAXN];
    logic [OW-1:0]        acc   [MAXN][MAXN];

    for (genvar i = 0; i < int'(MAXN); i++) begin : g_row
        for (genvar j = 0; j < int'(MAXN); j++) begin : g_col
            logic signed [DW-1:0]   a_in;
            logic signed [DW-1:0]   b_in;
            logic signed [2*DW-1:0] prod;
            logic [OW-1:0]          acc_q;
            logic                   active;

            if (j == 0) begin : g_west
                assign a_in = w_edge[i];
            end else begin : g_a
                assign a_in = a_fwd[i][j-1];
            end

            if (i == 0) begin : g_north
                assign b_in = n_edge[j];
            end else begin : g_b
                assign b_in = b_fwd[i-1][j];
            end

            assign active = (CW'(i) < n_q) && (CW'(j) < n_q);
            assign prod   = (2*DW)'(a_in) * (2*DW)'(b_in);

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    acc_q <= '0;
                end else if (load_last) begin
                    acc_q <= '0;
                end else if ((state == FEED) && active) begin
                    acc_q <= acc_q + {{(OW-2*DW){prod[2*DW-1]}}, prod};
                end
            end
            assign acc[i][j] = acc_q;

            if (j < int'(MAXN) - 1) begin : g_east
                logic signed [DW-1:0] a_q;
                always_ff @(posedge clk or negedge rst_n) begin
                    if (!rst_n) begin
                        a_q <= '0;
                    end else if (load_last) begin
                        a_q <= '0;
                    end else if ((state == FEED) && active) begin
                        a_q <= a_in;
                    end
                end
                assign a_fwd[i][j] = a_q;
            end

            if (i < int'(MAXN) - 1) begin : g_south
                logic signed [DW-1:0] b_q;
                always_ff @(posedge clk or negedge rst_n) begin
                    if (!rst_n) begin
                        b_q <= '0;
                    end else if (load_last) begin
                        b_q <= '0;
                    end else if ((state == FEED) && active) begin
                        b_q <= b_in;
                    end
                end
                assign b_fwd[i][j] = b_q;
            end
        end
    end

    // Outputs decode straight from state so reset clears them asynchronously.
    assign out_valid = (state == OUT);
    assign out_value = out_valid ? acc[row_q[IW-1:0]][col_q[IW-1:0]] : '0;

endmodule

// File: doc/sys_matmul.md
# sys_matmul

Parametrised output-stationary systolic matrix multiplier. It computes Y = W × X for square signed matrices of size 2×2, 4×4 or up to MAXN×MAXN, selected per job. It is the next generation of the fixed 2×2/4×4 processing-element array. Operands arrive as one serial word stream and results leave as a serial word stream, so the block drops in where the earlier array sat in the datapath.

## Interface
- DW, 16, operand width, signed two's complement
- MAXN, 4, largest supported matrix dimension; legal values 2, 4, 8; sets the physical PE array to MAXN×MAXN
- OW, 40, output width; must satisfy OW ≥ 2·DW + log2(MAXN)
- clk  input  1  clock; all state changes on the rising edge
- rst_n  input  1  reset, asynchronous, active-low
- in_valid  input  1  qualifies matrix; high for the whole job load
- matrix  input  DW  operand word
- matrix_size  input  2  size code: 0 → n=2, 1 → n=4, 2 → n=8; codes that give n>MAXN, and code 3, clamp to n=MAXN
- out_valid  output  1  qualifies out_value
- out_value  output  OW  result word, sign-extended Y element

## Operation
- FSM states:
  - IDLE: waiting for a job.
  - LOAD: capturing operands.
  - FEED: the array is computing.
  - OUT: streaming results.
- Reset value: state = IDLE; out_valid = 0; out_value = 0; all operand buffers, PE accumulators and counters = 0.
- IDLE → LOAD: on the first cycle with in_valid=1.
  - matrix_size is sampled on that cycle only and held for the job. It is ignored on all other cycles.
  - That cycle's matrix word is load index 0.
- LOAD: one word per cycle, 2·n² words in total.
  - Indices 0..n²−1 are W, row-major.
  - Indices n²..2n²−1 are X, row-major.
  - The word at index 2n²−1 ends LOAD and moves to FEED.
- Abort: in_valid=0 during LOAD before index 2n²−1.
  - Return to IDLE next cycle.
  - Discard partial data and clear counters; no output is produced.
- FEED: lasts exactly 3n−2 cycles.
  - Row i of W enters the west edge skewed by i cycles.
  - Column j of X enters the north edge skewed by j cycles.
  - Each active PE(i,j), i,j < n, does acc += west·north (full signed DW×DW product, sign-extended to OW) and forwards west→east and north→south with a 1-cycle register.
  - PEs outside the active n×n region receive 0 and hold 0.
  - Accumulators clear at FEED entry.
- OUT: n² cycles with out_valid=1, emitting Y[0][0], Y[0][1] … Y[n−1][n−1] (row-major), one per cycle.
  - out_value = acc(i,j) exactly, with no truncation or saturation; overflow is impossible by the OW rule.
- OUT → IDLE after the last element. out_valid=0 and out_value=0 in every cycle outside OUT.
- in_valid during FEED or OUT is ignored. The source must not start a job before returning to IDLE.

## Timing
- Let t = the cycle in which load index 2n²−1 is sampled.
- FEED occupies t+1 … t+3n−2.
- First out_valid is at t+3n−1; last out_valid is at t+3n−2+n².
- Totals from first in_valid to first out_valid: n=2: 12 cycles; n=4: 42 cycles; n=8: 150 cycles.
- Back-to-back jobs:
  - The cycle after the last out_valid is IDLE.
  - in_valid may assert in that cycle, and it becomes load index 0 of the next job.
  - The size may change between jobs.
- out_valid is continuous within a job, with no gaps.
- Reset mid-job (any state): outputs go to 0 immediately (asynchronously) and the FSM goes to IDLE. The first job after rst_n deasserts behaves exactly like a job after power-up.

## Test plan
- 2×2, W=[1,2;3,4], X=[5,6;7,8] → out_valid for 4 cycles starting t+5, values 19, 22, 43, 50.
- 4×4 with MAXN=4, W=identity, X=1..16 row-major → 16 consecutive outputs 1..16, first at t+11.
- Signed extremes, 2×2, all W and X = −32768 → four outputs of 2147483648 (0x0080000000). Repeat with W all −32768 and X all 32767 → four outputs of −2147418112, sign-extended to 40 bits.
- MAXN=8, code 2, all operands 0x7FFF → 64 outputs of 8589410312. With MAXN=4, code 2 clamps to n=4 → 16 outputs of 4294705156.
- Abort then recover: 2×2 job with in_valid dropped after 3 words → no out_valid. The next full 2×2 job from the first scenario yields 19, 22, 43, 50.
- Back-to-back and reset:
  - A 4×4 job followed by a 2×2 job with in_valid asserted in the cycle after the last out_valid → both result sets are correct.
  - rst_n pulsed low during OUT → out_valid drops at once, and no further output appears until a new job.
